// File: rtl/pingpong_pkg.sv
// Shared definitions for the ping-pong buffer read side.
//   NR_OF_ENTRIES / HALF_ENTRIES : buffer size and the size of one half
//   BITWIDTH                     : data word width
//   ADDR_W                       : pop address width (matches pingpongbuffer)
//   LEN_W                        : burst length width
//   state_t                      : read controller FSM states
//   clamp_len                    : maps a requested length onto 1..HALF_ENTRIES
package pingpong_pkg;

    localparam int NR_OF_ENTRIES = 64;
    localparam int HALF_ENTRIES  = NR_OF_ENTRIES / 2;
    localparam int BITWIDTH      = 32;
    localparam int ADDR_W        = 7;
    localparam int LEN_W         = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        READ   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // A length of 0, or one larger than a half, means "the whole half".
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len == '0 || len > LEN_W'(HALF_ENTRIES)) begin
            return LEN_W'(HALF_ENTRIES);
        end
        return len;
    endfunction

endpackage

// File: rtl/pingpong_skid_fifo.sv
// Two-entry FIFO holding words returned by the SSRAM read port.
//   clock, reset : clock and asynchronous active-low reset
//   push         : write pushData this cycle
//   pushData     : word to store
//   pop          : consumer takes the head word this cycle
//   popData      : head word (registered storage, stable while not popped)
//   count        : number of stored words (0..2)
// A push and pop in the same cycle leave count unchanged and add no bubble.
module pingpong_skid_fifo
    import pingpong_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic [BITWIDTH-1:0] pushData,
    input  logic                pop,
    output logic [BITWIDTH-1:0] popData,
    output logic [1:0]          count
);

    logic [BITWIDTH-1:0] mem_q [2];
    logic [BITWIDTH-1:0] mem_d [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;
    logic                do_push;
    logic                do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && (count_q != 2'd0);
        // When full, a push is only legal if the head leaves in the same cycle;
        // the write then lands in the slot being vacated.
        do_push  = push && ((count_q != 2'd2) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = pushData;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign popData = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/pingpong_pop_reader.sv
// Read-side controller for the ping-pong buffer.
//   clock, reset : clock and asynchronous active-low reset
//   bufferReady  : 1-cycle pulse, write side filled a half; burstLength sampled with it
//   switch       : 1-cycle pulse that flips the pingpongbuffer pop half
//   popAddress   : read address into the pop half (1-cycle SSRAM latency on popData)
//   outData/outValid/outReady : output stream; a word moves when outValid & outReady.
//                  outData/outValid stay stable while outValid=1 and outReady=0.
//   busy         : a burst is in progress (SWITCH, READ or DRAIN)
//   done         : 1-cycle pulse after the last word of a burst has moved
//   overrun      : 1-cycle pulse when a request arrives while one is already pending
//   debugState   : current FSM state
module pingpong_pop_reader
    import pingpong_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                bufferReady,
    input  logic [LEN_W-1:0]    burstLength,
    output logic                switch,
    output logic [ADDR_W-1:0]   popAddress,
    input  logic [BITWIDTH-1:0] popData,
    output logic [BITWIDTH-1:0] outData,
    output logic                outValid,
    input  logic                outReady,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output state_t              debugState
);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  pend_len_q, pend_len_d;
    logic              pending_q, pending_d;
    logic              in_flight_q, in_flight_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              issue;
    logic              credit_ok;
    logic              fifo_pop;
    logic [1:0]        fifo_count;

    pingpong_skid_fifo u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (in_flight_q),
        .pushData (popData),
        .pop      (fifo_pop),
        .popData  (outData),
        .count    (fifo_count)
    );

    assign outValid = (fifo_count != 2'd0);
    assign fifo_pop = outValid && outReady;

    // Words stored plus the word still coming back from the SSRAM, less the one
    // leaving this cycle, must stay below 2 so the 2-entry FIFO cannot overflow.
    // Written as a < b + pop to avoid an unsigned underflow.
    assign credit_ok = ({1'b0, fifo_count} + 3'(in_flight_q)) < (3'd2 + 3'(fifo_pop));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        pend_len_d = pend_len_q;
        pending_d  = pending_q;
        issue      = 1'b0;
        switch     = 1'b0;
        done       = 1'b0;
        overrun    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    // Serve the queued request; a new one arriving now takes its place.
                    state_d   = SWITCH;
                    len_d     = pend_len_q;
                    pending_d = bufferReady;
                    if (bufferReady) begin
                        pend_len_d = clamp_len(burstLength);
                    end
                end else if (bufferReady) begin
                    state_d = SWITCH;
                    len_d   = clamp_len(burstLength);
                end
            end
            SWITCH: begin
                switch  = 1'b1;
                idx_d   = '0;
                state_d = READ;
            end
            READ: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    idx_d = idx_q + LEN_W'(1);
                    if (idx_q == len_q - LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!in_flight_q && fifo_count == 2'd0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A request during a burst (including the done cycle) is queued one deep.
        if (bufferReady && state_q != IDLE) begin
            if (pending_q) begin
                overrun = 1'b1;
            end else begin
                pending_d  = 1'b1;
                pend_len_d = clamp_len(burstLength);
            end
        end

        in_flight_d = issue;
        addr_d      = issue ? ADDR_W'(idx_q) : addr_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            pend_len_q  <= '0;
            pending_q   <= 1'b0;
            in_flight_q <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            pend_len_q  <= pend_len_d;
            pending_q   <= pending_d;
            in_flight_q <= in_flight_d;
            addr_q      <= addr_d;
        end
    end

    // The address must be on the port in the cycle the read is issued.
    assign popAddress = addr_d;
    assign busy       = (state_q != IDLE);
    assign debugState = state_q;

endmodule
